rref_matrix_loader: RTL and testbench

- Upstream feeder for the combinational 5x5 Gauss-Jordan inversion stage.
- Accepts a row-major stream of 32-bit matrix elements over a valid/ready handshake and assembles them into the 25-word A operand and the 25-word B operand (identity by default).
- Holds both operands stable while the deep combinational stage settles, then asserts `mat_valid` until the consumer acknowledges.
- Flags framing errors and a zero leading pivot (`a00 == 0`), which would make the downstream divider divide by zero.

---
 rtl/rref_pkg.sv | 26 ++
 rtl/rref_matrix_loader.sv | 118 +++++++++++
 tb/tb_rref_matrix_loader.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rref_pkg.sv
// Shared definitions for the Gauss-Jordan inversion front end: operand geometry,
// loader state encoding and the identity operand used when B is not streamed.
package rref_pkg;

    localparam int RREF_N      = 5;
    localparam int RREF_WORD_W = 32;
    localparam int RREF_NELEM  = RREF_N * RREF_N;
    localparam int RREF_FLAT_W = RREF_NELEM * RREF_WORD_W;

    typedef enum logic [1:0] {
        ST_FILL_A = 2'd0,
        ST_FILL_B = 2'd1,
        ST_HOLD   = 2'd2
    } rref_state_e;

    // Diagonal words sit every RREF_N+1 words in the row-major packing.
    function automatic logic [RREF_FLAT_W-1:0] rref_identity();
        logic [RREF_FLAT_W-1:0] v;
        v = '0;
        for (int r = 0; r < RREF_N; r++) begin
            v[RREF_WORD_W*(r*(RREF_N+1)) +: RREF_WORD_W] = RREF_WORD_W'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/rref_matrix_loader.sv
// Streams row-major matrix elements into the A (and optionally B) operands of the
// combinational 5x5 inversion stage, holds them while it settles, then hands off.
module rref_matrix_loader
    import rref_pkg::*;
#(
    parameter bit LOAD_B        = 1'b0,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [RREF_WORD_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [RREF_FLAT_W-1:0] a_flat,
    output logic [RREF_FLAT_W-1:0] b_flat,
    output logic                   mat_valid,
    input  logic                   mat_ack,
    output logic                   frame_err,
    output logic                   zero_pivot
);

    localparam logic [4:0] LAST_IDX = 5'(RREF_NELEM - 1);
    localparam logic [8:0] SETTLE_W = 9'(SETTLE_CYCLES);

    rref_state_e            r_state;
    logic [4:0]             r_idx;
    logic [7:0]             r_cnt;
    logic [RREF_FLAT_W-1:0] r_a;
    logic [RREF_FLAT_W-1:0] r_b;
    logic                   r_mat_valid;
    logic                   r_frame_err;
    logic                   r_zero_pivot;

    logic                   w_accept;
    logic                   w_word_last;
    logic                   w_frame_end;
    logic                   w_bad;
    logic [8:0]             w_cnt_next;

    // NOTE: in_ready is a pure decode of the state register so the upstream
    // handshake never sees a path from in_valid back to in_ready.
    assign in_ready    = (r_state != ST_HOLD);
    assign w_accept    = in_valid && in_ready;
    assign w_word_last = (r_idx == LAST_IDX);
    assign w_frame_end = w_word_last && ((r_state == ST_FILL_B) || !LOAD_B);
    assign w_bad       = (in_last != w_frame_end);
    assign w_cnt_next  = {1'b0, r_cnt} + 9'd1;

    assign a_flat     = r_a;
    assign b_flat     = LOAD_B ? r_b : rref_identity();
    assign mat_valid  = r_mat_valid;
    assign frame_err  = r_frame_err;
    assign zero_pivot = r_zero_pivot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FILL_A;
            r_idx        <= '0;
            r_cnt        <= '0;
            // NOTE: the operand registers are reset too, because a_flat must read
            // as all-zero out of reset rather than whatever the flops power up to.
            r_a          <= '0;
            r_b          <= '0;
            r_mat_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_zero_pivot <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_FILL_A, ST_FILL_B: begin
                    if (w_accept) begin
                        if (r_state == ST_FILL_A) begin
                            r_a[RREF_WORD_W*r_idx +: RREF_WORD_W] <= in_data;
                        end else begin
                            r_b[RREF_WORD_W*r_idx +: RREF_WORD_W] <= in_data;
                        end
                        // A misframed element is still stored; the partial frame is
                        // simply overwritten by the next one.
                        if (w_bad) begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_FILL_A;
                            r_idx       <= '0;
                        end else if (w_frame_end) begin
                            r_state      <= ST_HOLD;
                            r_idx        <= '0;
                            r_cnt        <= '0;
                            r_zero_pivot <= (r_a[RREF_WORD_W-1:0] == '0);
                        end else if (w_word_last) begin
                            r_state <= ST_FILL_B;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_mat_valid) begin
                        if (mat_ack) begin
                            r_mat_valid <= 1'b0;
                            r_state     <= ST_FILL_A;
                            r_idx       <= '0;
                        end
                    end else begin
                        r_cnt <= w_cnt_next[7:0];
                        if (w_cnt_next == SETTLE_W) begin
                            r_mat_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_FILL_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rref_matrix_loader.sv
// Bench for rref_matrix_loader: one instance per LOAD_B setting, a frame-level
// reference model, a per-cycle output compare, and directed plus random frames.
module tb_rref_matrix_loader;

    localparam int S = 4;
    localparam int W = 800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid [2];
    logic        in_last  [2];
    logic        mat_ack  [2];
    logic [31:0] in_data  [2];
    logic        in_ready [2];
    logic        mat_valid[2];
    logic        frame_err[2];
    logic        zero_pivot[2];
    logic [W-1:0] a_flat  [2];
    logic [W-1:0] b_flat  [2];

    int total = 0;
    int bad   = 0;

    // Model: position within the frame, cycles spent holding (-1 = accepting).
    int          m_pos [2];
    int          m_hold[2];
    bit          m_ferr[2];
    bit          m_zp  [2];
    logic [31:0] m_a   [2][25];
    logic [31:0] m_b   [2][25];

    always #5 clk = ~clk;

    rref_matrix_loader #(.LOAD_B(1'b0), .SETTLE_CYCLES(S)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_data(in_data[0]), .in_last(in_last[0]),
        .in_ready(in_ready[0]), .a_flat(a_flat[0]), .b_flat(b_flat[0]),
        .mat_valid(mat_valid[0]), .mat_ack(mat_ack[0]),
        .frame_err(frame_err[0]), .zero_pivot(zero_pivot[0])
    );

    rref_matrix_loader #(.LOAD_B(1'b1), .SETTLE_CYCLES(S)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_data(in_data[1]), .in_last(in_last[1]),
        .in_ready(in_ready[1]), .a_flat(a_flat[1]), .b_flat(b_flat[1]),
        .mat_valid(mat_valid[1]), .mat_ack(mat_ack[1]),
        .frame_err(frame_err[1]), .zero_pivot(zero_pivot[1])
    );

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s timed out", nm);
    endtask

    function automatic logic [W-1:0] ident();
        logic [W-1:0] v;
        v = '0;
        for (int r = 0; r < 5; r++) v[32*(6*r) +: 32] = 32'd1;
        return v;
    endfunction

    function automatic logic [W-1:0] model_flat(input int i, input bit is_b);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < 25; k++) v[32*k +: 32] = is_b ? m_b[i][k] : m_a[i][k];
        return v;
    endfunction

    function automatic logic [31:0] word(input logic [W-1:0] v, input int k);
        return v[32*k +: 32];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i]  = 0;
            m_hold[i] = -1;
            m_ferr[i] = 1'b0;
            m_zp[i]   = 1'b0;
            for (int k = 0; k < 25; k++) begin
                m_a[i][k] = '0;
                m_b[i][k] = '0;
            end
        end
    endtask

    // One clock edge of frame-level behaviour for instance i.
    task automatic model_step(input int i);
        int  len;
        bit  is_final;
        len       = (i == 1) ? 50 : 25;
        m_ferr[i] = 1'b0;
        if (m_hold[i] < 0) begin
            if (in_valid[i]) begin
                if (m_pos[i] < 25) m_a[i][m_pos[i]] = in_data[i];
                else               m_b[i][m_pos[i]-25] = in_data[i];
                is_final = (m_pos[i] == len - 1);
                if (in_last[i] != is_final) begin
                    m_ferr[i] = 1'b1;
                    m_pos[i]  = 0;
                end else if (is_final) begin
                    m_hold[i] = 0;
                    m_zp[i]   = (m_a[i][0] == 32'd0);
                    m_pos[i]  = 0;
                end else begin
                    m_pos[i]++;
                end
            end
        end else if (m_hold[i] >= S) begin
            if (mat_ack[i]) m_hold[i] = -1;
        end else begin
            m_hold[i]++;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("in_ready%0d", i), in_ready[i], m_hold[i] < 0);
                check($sformatf("mat_valid%0d", i), mat_valid[i], m_hold[i] >= S);
                check($sformatf("frame_err%0d", i), frame_err[i], m_ferr[i]);
                check($sformatf("a_flat%0d", i), a_flat[i], model_flat(i, 1'b0));
                check($sformatf("b_flat%0d", i), b_flat[i], (i == 1) ? model_flat(i, 1'b1) : ident());
                if (m_hold[i] >= S) check($sformatf("zero_pivot%0d", i), zero_pivot[i], m_zp[i]);
            end
        end
    end

    // Drive one element (caller is at a negedge); returns at the negedge after acceptance.
    task automatic push(input int i, input logic [31:0] d, input bit last);
        bit rdy;
        int n;
        n = 0;
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        in_last[i]  = last;
        do begin
            rdy = in_ready[i];
            @(negedge clk);
            n++;
        end while (!rdy && n < 200);
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
        if (!rdy) timeout($sformatf("push%0d", i));
    endtask

    // Count negedges until mat_valid is seen; optional ack noise while waiting.
    task automatic wait_valid(input int i, input bit noise, output int n);
        n = 0;
        while (mat_valid[i] !== 1'b1 && n < 200) begin
            if (noise) mat_ack[i] = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (noise) mat_ack[i] = 1'b0;
        if (n >= 200) timeout($sformatf("wait_valid%0d", i));
    endtask

    task automatic ack_and_check(input int i);
        mat_ack[i] = 1'b1;
        @(negedge clk);
        mat_ack[i] = 1'b0;
        check("ack_valid_low", mat_valid[i], 1'b0);
        check("ack_ready_high", in_ready[i], 1'b1);
    endtask

    task automatic rand_run(input int i, input int nfr);
        int          len, mode, e, n, stop;
        logic [31:0] d;
        bit          last;
        len = (i == 1) ? 50 : 25;
        for (int f = 0; f < nfr; f++) begin
            mode = $urandom_range(0, 5);
            e    = $urandom_range(0, len - 2);
            stop = (mode == 0) ? e : len - 1;
            for (int p = 0; p <= stop; p++) begin
                d = $urandom;
                if (p == 0 && $urandom_range(0, 3) == 0) d = 32'd0;
                if (mode == 0)      last = (p == e);
                else if (mode == 1) last = 1'b0;
                else                last = (p == len - 1);
                push(i, d, last);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        mat_ack[i] = 1'($urandom_range(0, 1));
                        @(negedge clk);
                    end
                    mat_ack[i] = 1'b0;
                end
            end
            if (mode >= 2) begin
                wait_valid(i, 1'b1, n);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                mat_ack[i] = 1'b1;
                @(negedge clk);
                mat_ack[i] = 1'b0;
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            in_last[i]  = 1'b0;
            mat_ack[i]  = 1'b0;
            in_data[i]  = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready[0], 1'b1);
        check("rst_valid", mat_valid[0], 1'b0);
        check("rst_ferr", frame_err[1], 1'b0);
        check("rst_zp", zero_pivot[0], 1'b0);
        check("rst_a", a_flat[0], '0);
        check("rst_b0_ident", b_flat[0], ident());
        check("rst_b1_zero", b_flat[1], '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Values 1..25, B identity, four-cycle settle, nonzero pivot.
        for (int k = 0; k < 25; k++) push(0, 32'(k + 1), k == 24);
        check("hold_not_ready", in_ready[0], 1'b0);
        wait_valid(0, 1'b0, n);
        check("settle_latency", 32'(n), 32'd4);
        check("a_word7", word(a_flat[0], 7), 32'd8);
        check("a_word24", word(a_flat[0], 24), 32'd25);
        check("b_ident", b_flat[0], ident());
        check("zp_clear", zero_pivot[0], 1'b0);
        ack_and_check(0);

        // Zero leading pivot.
        for (int k = 0; k < 25; k++) push(0, (k == 0) ? 32'd0 : 32'(k + 3), k == 24);
        wait_valid(0, 1'b0, n);
        check("zp_set", zero_pivot[0], 1'b1);
        ack_and_check(0);

        // Early in_last on element 10, then a clean frame.
        for (int k = 0; k < 10; k++) push(0, 32'(200 + k), k == 9);
        check("ferr_pulse", frame_err[0], 1'b1);
        check("ferr_ready", in_ready[0], 1'b1);
        @(negedge clk);
        check("ferr_one_cycle", frame_err[0], 1'b0);
        for (int k = 0; k < 25; k++) push(0, 32'(100 + k), k == 24);
        wait_valid(0, 1'b0, n);
        check("after_err_latency", 32'(n), 32'd4);
        check("after_err_word0", word(a_flat[0], 0), 32'd100);
        ack_and_check(0);

        // LOAD_B=1: A = 2 on diagonal, B = 7 everywhere.
        for (int k = 0; k < 50; k++)
            push(1, (k >= 25) ? 32'd7 : ((k % 6 == 0) ? 32'd2 : 32'd0), k == 49);
        wait_valid(1, 1'b0, n);
        check("lb_latency", 32'(n), 32'd4);
        check("lb_a6", word(a_flat[1], 6), 32'd2);
        check("lb_a1", word(a_flat[1], 1), 32'd0);
        check("lb_b13", word(b_flat[1], 13), 32'd7);
        check("lb_zp", zero_pivot[1], 1'b0);
        ack_and_check(1);

        // mat_ack held high from reset.
        rst_n = 1'b0;
        mat_ack[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 25; k++) push(0, 32'(k + 9), k == 24);
        wait_valid(0, 1'b0, n);
        check("ackhold_latency", 32'(n), 32'd4);
        @(negedge clk);
        check("ackhold_valid_low", mat_valid[0], 1'b0);
        check("ackhold_ready", in_ready[0], 1'b1);
        mat_ack[0] = 1'b0;

        // Asynchronous reset after element 12.
        for (int k = 0; k < 12; k++) push(1, 32'(300 + k), 1'b0);
        for (int k = 0; k < 12; k++) push(0, 32'(400 + k), 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_a0", a_flat[0], '0);
        check("arst_b1", b_flat[1], '0);
        check("arst_ready", in_ready[0], 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 25; k++) push(0, 32'(50 + k), k == 24);
        wait_valid(0, 1'b0, n);
        check("arst_reload_w0", word(a_flat[0], 0), 32'd50);
        check("arst_reload_w12", word(a_flat[0], 12), 32'd62);
        ack_and_check(0);

        fork
            rand_run(0, 30);
            rand_run(1, 15);
        join
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
